// File: rtl/id_ex_stage_pkg.sv
// Shared types for the combined decode/execute pipeline slice.
// Opcode and condition encodings, field positions and the ID/EX bundle.
package id_ex_stage_pkg;

    localparam int XLEN        = 32;
    localparam int OP_LSB      = 27;
    localparam int D_LSB       = 22;
    localparam int S_LSB       = 17;
    localparam int T_LSB       = 12;
    localparam int COND_LSB    = 24;
    localparam int IMM_W       = 17;
    localparam int SPR_ADR_LSB = 19;
    localparam int SPR_ACT_LSB = 15;
    localparam int SPR_IMM_BIT = 14;
    localparam int SPR_LIT_W   = 10;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_ADDI = 5'b00001,
        OP_SUB  = 5'b00010,
        OP_SUBI = 5'b00011,
        OP_AND  = 5'b00100,
        OP_OR   = 5'b00101,
        OP_XOR  = 5'b00110,
        OP_B    = 5'b00111,
        OP_SLL  = 5'b01000,
        OP_SRL  = 5'b01001,
        OP_SRA  = 5'b01010,
        OP_SPR  = 5'b11000,
        OP_NOP  = 5'b11110,
        OP_HLT  = 5'b11111
    } opcode_e;

    typedef enum logic [2:0] {
        CC_EQ, CC_NE, CC_LT, CC_GE,
        CC_CS, CC_OV, CC_NV, CC_AL
    } cond_e;

    typedef struct packed {
        opcode_e         op;
        logic [4:0]      dst;
        cond_e           cond;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [7:0]      spr_addr;
        logic [3:0]      spr_act;
        logic [XLEN-1:0] spr_data;
    } id_ex_t;

    // Unassigned encodings (including 11110) all collapse to NOP.
    function automatic opcode_e decode_op(input logic [4:0] raw);
        opcode_e op;
        if (raw <= 5'd10 || raw == 5'd24 || raw == 5'd31)
            op = opcode_e'(raw);
        else
            op = OP_NOP;
        return op;
    endfunction

    function automatic logic is_alu(input opcode_e op);
        return op inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
                          OP_AND, OP_OR, OP_XOR,
                          OP_SLL, OP_SRL, OP_SRA};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between the ID/EX slice and its neighbours (fetch, regfile,
// MEM/WB, PC logic, sprite unit).
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic [DW-1:0] instr;
    logic [DW-1:0] pc_in;
    logic [DW-1:0] regS_data;
    logic [DW-1:0] regT_data;
    logic [RW-1:0] regS_addr;
    logic [RW-1:0] regT_addr;
    logic          reS;
    logic          reT;
    logic          branch_instr;
    logic [DW-1:0] alu_result;
    logic [RW-1:0] dst_reg;
    logic          wb_en;
    logic [DW-1:0] rec_PC;
    logic          br_taken;
    logic [7:0]    sprite_addr;
    logic [3:0]    sprite_action;
    logic [DW-1:0] sprite_data;
    logic          sprite_we;
    logic          hlt;
    logic          flag_ov;
    logic          flag_sign;
    logic          flag_zero;
    logic          flag_carry;

    modport master (
        output instr, pc_in, regS_data, regT_data,
        input  regS_addr, regT_addr, reS, reT, branch_instr,
        input  alu_result, dst_reg, wb_en, rec_PC, br_taken,
        input  sprite_addr, sprite_action, sprite_data, sprite_we,
        input  hlt, flag_ov, flag_sign, flag_zero, flag_carry
    );

    modport slave (
        input  instr, pc_in, regS_data, regT_data,
        output regS_addr, regT_addr, reS, reT, branch_instr,
        output alu_result, dst_reg, wb_en, rec_PC, br_taken,
        output sprite_addr, sprite_action, sprite_data, sprite_we,
        output hlt, flag_ov, flag_sign, flag_zero, flag_carry
    );
endinterface

// File: rtl/id_ex_alu.sv
// Combinational execute ALU with flag generation.
// upd_all_o marks arithmetic ops, upd_zs_o marks logic/shift ops.
module id_ex_alu
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  opcode_e       op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] res_o,
    output logic          upd_all_o,
    output logic          upd_zs_o,
    output logic          ov_o,
    output logic          sign_o,
    output logic          zero_o,
    output logic          carry_o
);
    logic [DW:0] sum;

    always_comb begin
        sum       = '0;
        res_o     = '0;
        upd_all_o = 1'b0;
        upd_zs_o  = 1'b0;
        ov_o      = 1'b0;
        carry_o   = 1'b0;
        unique case (op_i)
            OP_ADD, OP_ADDI: begin
                sum       = {1'b0, a_i} + {1'b0, b_i};
                res_o     = sum[DW-1:0];
                carry_o   = sum[DW];
                ov_o      = (a_i[DW-1] == b_i[DW-1]) &&
                            (res_o[DW-1] != a_i[DW-1]);
                upd_all_o = 1'b1;
            end
            OP_SUB, OP_SUBI: begin
                // Borrow out of the extended subtract means a < b.
                sum       = {1'b0, a_i} - {1'b0, b_i};
                res_o     = sum[DW-1:0];
                carry_o   = ~sum[DW];
                ov_o      = (a_i[DW-1] != b_i[DW-1]) &&
                            (res_o[DW-1] != a_i[DW-1]);
                upd_all_o = 1'b1;
            end
            OP_AND: begin res_o = a_i & b_i; upd_zs_o = 1'b1; end
            OP_OR:  begin res_o = a_i | b_i; upd_zs_o = 1'b1; end
            OP_XOR: begin res_o = a_i ^ b_i; upd_zs_o = 1'b1; end
            OP_SLL: begin res_o = a_i << b_i[4:0]; upd_zs_o = 1'b1; end
            OP_SRL: begin res_o = a_i >> b_i[4:0]; upd_zs_o = 1'b1; end
            OP_SRA: begin
                res_o    = $signed(a_i) >>> b_i[4:0];
                upd_zs_o = 1'b1;
            end
            default: ;
        endcase
        sign_o = res_o[DW-1];
        zero_o = (res_o == '0);
    end
endmodule

// File: rtl/id_ex_stage.sv
// Decode (combinational regfile addressing) plus ID/EX register and
// execute: ALU, flags, branch resolution and sprite command.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    opcode_e       op_id;
    logic          use_imm;
    logic          imm_form;
    logic [DW-1:0] imm_id;
    id_ex_t        idex_d, idex_q;

    logic [DW-1:0] alu_res;
    logic          upd_all, upd_zs;
    logic          alu_ov, alu_sign, alu_zero, alu_carry;
    logic          ov_d, sign_d, zero_d, carry_d;
    logic          ov_q, sign_q, zero_q, carry_q;
    logic          cond_ok, taken;

    assign op_id    = decode_op(bus.instr[OP_LSB +: 5]);
    assign use_imm  = bus.instr[SPR_IMM_BIT];
    assign imm_form = op_id inside {OP_ADDI, OP_SUBI};
    assign imm_id   = {{(DW-IMM_W){bus.instr[IMM_W-1]}},
                       bus.instr[IMM_W-1:0]};

    always_comb begin
        bus.regS_addr = '0;
        bus.regT_addr = '0;
        bus.reS       = 1'b0;
        bus.reT       = 1'b0;
        if (is_alu(op_id)) begin
            bus.regS_addr = bus.instr[S_LSB +: RW];
            bus.reS       = 1'b1;
            if (!imm_form) begin
                bus.regT_addr = bus.instr[T_LSB +: RW];
                bus.reT       = 1'b1;
            end
        end else if (op_id == OP_SPR && !use_imm) begin
            bus.regS_addr = bus.instr[RW-1:0];
            bus.reS       = 1'b1;
        end
    end

    assign bus.branch_instr = (op_id == OP_B);

    always_comb begin
        idex_d      = '0;
        idex_d.op   = op_id;
        idex_d.dst  = bus.instr[D_LSB +: RW];
        idex_d.cond = cond_e'(bus.instr[COND_LSB +: 3]);
        idex_d.a    = bus.regS_data;
        idex_d.b    = imm_form ? imm_id : bus.regT_data;
        idex_d.pc   = bus.pc_in;
        idex_d.imm  = imm_id;
        if (op_id == OP_SPR) begin
            idex_d.spr_addr = bus.instr[SPR_ADR_LSB +: 8];
            idex_d.spr_act  = bus.instr[SPR_ACT_LSB +: 4];
            idex_d.spr_data = use_imm ?
                {{(DW-SPR_LIT_W){1'b0}}, bus.instr[SPR_LIT_W-1:0]} :
                bus.regS_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q    <= '0;
            idex_q.op <= OP_NOP;
        end else begin
            idex_q <= idex_d;
        end
    end

    id_ex_alu #(.DW(DW)) u_alu (
        .op_i      (idex_q.op),
        .a_i       (idex_q.a),
        .b_i       (idex_q.b),
        .res_o     (alu_res),
        .upd_all_o (upd_all),
        .upd_zs_o  (upd_zs),
        .ov_o      (alu_ov),
        .sign_o    (alu_sign),
        .zero_o    (alu_zero),
        .carry_o   (alu_carry)
    );

    always_comb begin
        ov_d    = ov_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        if (upd_all || upd_zs) begin
            sign_d = alu_sign;
            zero_d = alu_zero;
        end
        if (upd_all) begin
            ov_d    = alu_ov;
            carry_d = alu_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ov_q    <= 1'b0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            ov_q    <= ov_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        cond_ok = 1'b0;
        unique case (idex_q.cond)
            CC_EQ: cond_ok = zero_q;
            CC_NE: cond_ok = ~zero_q;
            CC_LT: cond_ok = sign_q ^ ov_q;
            CC_GE: cond_ok = ~(sign_q ^ ov_q);
            CC_CS: cond_ok = carry_q;
            CC_OV: cond_ok = ov_q;
            CC_NV: cond_ok = 1'b0;
            CC_AL: cond_ok = 1'b1;
        endcase
    end

    assign taken = (idex_q.op == OP_B) && cond_ok;

    assign bus.alu_result    = alu_res;
    assign bus.dst_reg       = idex_q.dst;
    assign bus.wb_en         = is_alu(idex_q.op);
    assign bus.br_taken      = taken;
    assign bus.rec_PC        = idex_q.pc + {{(DW-1){1'b0}}, 1'b1} +
                               (taken ? idex_q.imm : '0);
    assign bus.sprite_addr   = idex_q.spr_addr;
    assign bus.sprite_action = idex_q.spr_act;
    assign bus.sprite_data   = idex_q.spr_data;
    assign bus.sprite_we     = (idex_q.op == OP_SPR);
    assign bus.hlt           = (idex_q.op == OP_HLT);
    assign bus.flag_ov       = ov_q;
    assign bus.flag_sign     = sign_q;
    assign bus.flag_zero     = zero_q;
    assign bus.flag_carry    = carry_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, randomized run against
// an arithmetic reference model, and reset corner sequences.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] s;
        logic [31:0] t;
        logic [31:0] alu;
        logic        wb;
        logic [4:0]  dst;
        logic [31:0] rec;
        logic        tk;
        logic        we;
        logic [31:0] sdata;
        logic        hlt;
        logic [3:0]  flags;
    } row_t;

    typedef struct packed {
        logic [31:0] alu;
        logic        wb;
        logic [4:0]  dst;
        logic [31:0] rec;
        logic        tk;
        logic        we;
        logic [7:0]  saddr;
        logic [3:0]  sact;
        logic [31:0] sdata;
        logic        hlt;
        logic [3:0]  nflags;
    } exp_t;

    typedef struct packed {
        logic [4:0] sa;
        logic [4:0] ta;
        logic       rs;
        logic       rt;
        logic       br;
    } dec_t;

    row_t       rows [11];
    logic [3:0] mflags;
    logic [4:0] ops [16] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
                             5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd24,
                             5'd31, 5'd12, 5'd20, 5'd30};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic dec_t dec_model(input logic [31:0] ins);
        dec_t d;
        logic [4:0] op;
        d  = '0;
        op = ins[31:27];
        if (op <= 5'd10 && op != 5'd7) begin
            d.sa = ins[21:17];
            d.rs = 1'b1;
            if (op != 5'd1 && op != 5'd3) begin
                d.ta = ins[16:12];
                d.rt = 1'b1;
            end
        end else if (op == 5'd24 && !ins[14]) begin
            d.sa = ins[4:0];
            d.rs = 1'b1;
        end
        d.br = (op == 5'd7);
        return d;
    endfunction

    // f = {ov, sign, zero, carry} as held before this instruction.
    function automatic exp_t ex_model(input logic [31:0] ins, pc, s, t,
                                      input logic [3:0] f);
        exp_t        e;
        logic [4:0]  op;
        logic [31:0] imm, o;
        longint      sum, sres;
        logic        v, c, ok;
        int          sh;
        e        = '0;
        op       = ins[31:27];
        imm      = {{15{ins[16]}}, ins[16:0]};
        e.rec    = pc + 32'd1;
        e.nflags = f;
        e.dst    = ins[26:22];
        sh       = int'(t[4:0]);
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3: begin
                o = op[0] ? imm : t;
                if (op[1]) begin
                    e.alu = s - o;
                    c     = (s >= o);
                    sres  = longint'($signed(s)) - longint'($signed(o));
                end else begin
                    e.alu = s + o;
                    sum   = longint'(s) + longint'(o);
                    c     = (sum > 64'sh0FFFFFFFF);
                    sres  = longint'($signed(s)) + longint'($signed(o));
                end
                v = (sres > 64'sd2147483647) ||
                    (sres < -64'sd2147483648);
                e.wb     = 1'b1;
                e.nflags = {v, e.alu[31], e.alu == 32'd0, c};
            end
            5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10: begin
                case (op)
                    5'd4:    e.alu = s & t;
                    5'd5:    e.alu = s | t;
                    5'd6:    e.alu = s ^ t;
                    5'd8:    e.alu = s << sh;
                    5'd9:    e.alu = s >> sh;
                    default: e.alu = (s >> sh) |
                                 (s[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
                endcase
                e.wb     = 1'b1;
                e.nflags = {f[3], e.alu[31], e.alu == 32'd0, f[0]};
            end
            5'd7: begin
                case (ins[26:24])
                    3'd0:    ok = f[1];
                    3'd1:    ok = !f[1];
                    3'd2:    ok = f[2] ^ f[3];
                    3'd3:    ok = !(f[2] ^ f[3]);
                    3'd4:    ok = f[0];
                    3'd5:    ok = f[3];
                    3'd6:    ok = 1'b0;
                    default: ok = 1'b1;
                endcase
                e.tk = ok;
                if (ok) e.rec = pc + 32'd1 + imm;
            end
            5'd24: begin
                e.we    = 1'b1;
                e.saddr = ins[26:19];
                e.sact  = ins[18:15];
                e.sdata = ins[14] ? {22'd0, ins[9:0]} : s;
            end
            5'd31: e.hlt = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] dut_flags();
        return {bus.flag_ov, bus.flag_sign, bus.flag_zero, bus.flag_carry};
    endfunction

    // Present one instruction in ID, check decode, then step into EX.
    task automatic drive(input logic [31:0] ins, pc, s, t);
        dec_t d;
        @(negedge clk);
        bus.instr     = ins;
        bus.pc_in     = pc;
        bus.regS_data = s;
        bus.regT_data = t;
        #1;
        d = dec_model(ins);
        chk("regS_addr", 32'(bus.regS_addr), 32'(d.sa));
        chk("regT_addr", 32'(bus.regT_addr), 32'(d.ta));
        chk("reS", 32'(bus.reS), 32'(d.rs));
        chk("reT", 32'(bus.reT), 32'(d.rt));
        chk("branch_instr", 32'(bus.branch_instr), 32'(d.br));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst alu_result", bus.alu_result, 32'd0);
        chk("rst wb_en", 32'(bus.wb_en), 32'd0);
        chk("rst br_taken", 32'(bus.br_taken), 32'd0);
        chk("rst sprite_we", 32'(bus.sprite_we), 32'd0);
        chk("rst hlt", 32'(bus.hlt), 32'd0);
        chk("rst rec_PC", bus.rec_PC, 32'd1);
        chk("rst flags", 32'(dut_flags()), 32'd0);
    endtask

    task automatic chk_ex(input exp_t e);
        chk("alu_result", bus.alu_result, e.alu);
        chk("wb_en", 32'(bus.wb_en), 32'(e.wb));
        chk("rec_PC", bus.rec_PC, e.rec);
        chk("br_taken", 32'(bus.br_taken), 32'(e.tk));
        chk("sprite_we", 32'(bus.sprite_we), 32'(e.we));
        chk("hlt", 32'(bus.hlt), 32'(e.hlt));
        if (e.wb) chk("dst_reg", 32'(bus.dst_reg), 32'(e.dst));
        if (e.we) begin
            chk("sprite_addr", 32'(bus.sprite_addr), 32'(e.saddr));
            chk("sprite_action", 32'(bus.sprite_action), 32'(e.sact));
            chk("sprite_data", bus.sprite_data, e.sdata);
        end
    endtask

    initial begin
        logic [31:0] r, ins, s, t, pc;
        exp_t        e;

        // instr, pc, s, t, alu, wb, dst, rec, tk, we, sdata, hlt, flags
        rows[0]  = '{32'h00443000, 32'h0, 32'd1, 32'd3, 32'd4,
                     1'b1, 5'd1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000};
        rows[1]  = '{32'h110A5000, 32'h1, 32'd5, 32'd5, 32'd0,
                     1'b1, 5'd4, 32'h2, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000};
        rows[2]  = '{32'h38000010, 32'h20, 32'd0, 32'd0, 32'd0,
                     1'b0, 5'd0, 32'h31, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0011};
        rows[3]  = '{32'h088C0001, 32'h40, 32'h7FFFFFFF, 32'd0,
                     32'h80000000, 1'b1, 5'd2, 32'h41, 1'b0, 1'b0, 32'h0,
                     1'b0, 4'b0011};
        rows[4]  = '{32'h38000005, 32'h50, 32'd0, 32'd0, 32'd0,
                     1'b0, 5'd0, 32'h51, 1'b0, 1'b0, 32'h0, 1'b0, 4'b1100};
        rows[5]  = '{32'h3D01FFFE, 32'h60, 32'd0, 32'd0, 32'd0,
                     1'b0, 5'd0, 32'h5F, 1'b1, 1'b0, 32'h0, 1'b0, 4'b1100};
        rows[6]  = '{32'hC091C155, 32'h70, 32'hDEADBEEF, 32'd0, 32'd0,
                     1'b0, 5'd0, 32'h71, 1'b0, 1'b1, 32'h155, 1'b0,
                     4'b1100};
        rows[7]  = '{32'hF8000000, 32'h80, 32'd0, 32'd0, 32'd0,
                     1'b0, 5'd0, 32'h81, 1'b0, 1'b0, 32'h0, 1'b1, 4'b1100};
        rows[8]  = '{32'h68000000, 32'h90, 32'd0, 32'd0, 32'd0,
                     1'b0, 5'd0, 32'h91, 1'b0, 1'b0, 32'h0, 1'b0, 4'b1100};
        rows[9]  = '{32'h30C22000, 32'hA0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                     32'd0, 1'b1, 5'd3, 32'hA1, 1'b0, 1'b0, 32'h0, 1'b0,
                     4'b1100};
        rows[10] = '{32'h38000100, 32'hB0, 32'd0, 32'd0, 32'd0,
                     1'b0, 5'd0, 32'h1B1, 1'b1, 1'b0, 32'h0, 1'b0,
                     4'b1010};

        // An ADD sits on instr during reset; reset must win.
        bus.instr     = 32'h00443000;
        bus.pc_in     = 32'h1234;
        bus.regS_data = 32'd7;
        bus.regT_data = 32'd9;
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(rows[i].instr, rows[i].pc, rows[i].s, rows[i].t);
            chk("tbl alu_result", bus.alu_result, rows[i].alu);
            chk("tbl wb_en", 32'(bus.wb_en), 32'(rows[i].wb));
            chk("tbl rec_PC", bus.rec_PC, rows[i].rec);
            chk("tbl br_taken", 32'(bus.br_taken), 32'(rows[i].tk));
            chk("tbl sprite_we", 32'(bus.sprite_we), 32'(rows[i].we));
            chk("tbl hlt", 32'(bus.hlt), 32'(rows[i].hlt));
            chk("tbl flags", 32'(dut_flags()), 32'(rows[i].flags));
            if (rows[i].wb)
                chk("tbl dst_reg", 32'(bus.dst_reg), 32'(rows[i].dst));
            if (rows[i].we)
                chk("tbl sprite_data", bus.sprite_data, rows[i].sdata);
        end

        // Reset with a HLT waiting in ID, then randomized run.
        @(negedge clk);
        rst_n     = 1'b0;
        bus.instr = 32'hF8000000;
        @(posedge clk);
        #1;
        chk_reset();
        rst_n  = 1'b1;
        mflags = 4'b0000;

        for (int i = 0; i < 400; i++) begin
            r   = $urandom();
            ins = {ops[$urandom_range(0, 15)], r[26:0]};
            s   = $urandom();
            t   = $urandom();
            pc  = $urandom();
            case ($urandom_range(0, 7))
                0: s = 32'h7FFFFFFF;
                1: s = 32'h80000000;
                2: s = 32'hFFFFFFFF;
                3: t = s;
                default: ;
            endcase
            drive(ins, pc, s, t);
            e = ex_model(ins, pc, s, t, mflags);
            chk_ex(e);
            chk("flags", 32'(dut_flags()), 32'(mflags));
            mflags = e.nflags;
        end

        // ADD producing Z=1,C=1, then reset while the next ADD is in flight.
        drive(32'h00443000, 32'h200, 32'hFFFFFFFF, 32'd1);
        e = ex_model(32'h00443000, 32'h200, 32'hFFFFFFFF, 32'd1, mflags);
        chk_ex(e);
        @(negedge clk);
        bus.instr     = 32'h00443000;
        bus.regS_data = 32'h80000000;
        bus.regT_data = 32'h80000000;
        rst_n         = 1'b0;
        @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
